// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared opcode type and default widths for the VeriRISC fetch stage.
package fetch_unit_pkg;
    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;
    localparam int OPC_MSB    = DWIDTH_DEF - 1;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: controller/memory-side bundle of the fetch stage; slave = fetch_unit, master = driver.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int AWIDTH      = AWIDTH_DEF,
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int CWIDTH      = 16,
    parameter int TRACE_DEPTH = 8
);
    localparam int IW = $clog2(TRACE_DEPTH);
    logic [DWIDTH-1:0] data_in;
    logic              load_ir;
    logic              inc_pc;
    logic              load_pc;
    logic              halt;
    logic              fetch;
    logic [IW-1:0]     trace_idx;
    opcode_t           opcode;
    logic [AWIDTH-1:0] ir_addr;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] mem_addr;
    logic              halted;
    logic [CWIDTH-1:0] fetch_count;
    logic [AWIDTH-1:0] trace_pc;
    logic [IW:0]       trace_fill;

    modport slave (
        input  data_in, load_ir, inc_pc, load_pc, halt, fetch, trace_idx,
        output opcode, ir_addr, pc, mem_addr, halted, fetch_count, trace_pc, trace_fill
    );
    modport master (
        output data_in, load_ir, inc_pc, load_pc, halt, fetch, trace_idx,
        input  opcode, ir_addr, pc, mem_addr, halted, fetch_count, trace_pc, trace_fill
    );
endinterface

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: loadable wrapping up-counter; load beats inc, nothing moves when en is low.
module pc_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            q <= '0;
        else if (en)
            q <= load ? d : inc ? q + 1'b1 : q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC + IR stage with sticky halt, saturating fetch counter and optional PC trace.
// Define FETCH_TRACE_EN to build the circular PC trace buffer; otherwise trace outputs read 0.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int AWIDTH      = AWIDTH_DEF,
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int CWIDTH      = 16,
    parameter int TRACE_DEPTH = 8
) (
    input logic        clk,
    input logic        reset,
    fetch_unit_if.slave bus
);
    localparam int IW = $clog2(TRACE_DEPTH);

    logic [DWIDTH-1:0] r_ir;
    logic              r_halted;
    logic [CWIDTH-1:0] r_count;
    logic [AWIDTH-1:0] w_pc;
    logic [AWIDTH-1:0] w_ir_addr;
    logic              w_en;
    logic              w_take;

    assign w_en      = ~r_halted;
    assign w_take    = w_en & bus.load_ir;
    assign w_ir_addr = r_ir[AWIDTH-1:0];

    // load_pc sees the operand held before the edge, so load_ir+load_pc jumps to the old target
    pc_counter #(.W(AWIDTH)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .load  (bus.load_pc),
        .inc   (bus.inc_pc),
        .d     (w_ir_addr),
        .q     (w_pc)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_ir     <= '0;
            r_halted <= 1'b0;
            r_count  <= '0;
        end else if (w_en) begin
            if (bus.load_ir)
                r_ir <= bus.data_in;
            if (bus.load_ir && r_count != '1)
                r_count <= r_count + 1'b1;
            if (bus.halt)
                r_halted <= 1'b1;
        end

    assign bus.opcode      = opcode_t'(r_ir[DWIDTH-1 -: 3]);
    assign bus.ir_addr     = w_ir_addr;
    assign bus.pc          = w_pc;
    assign bus.mem_addr    = bus.fetch ? w_pc : w_ir_addr;
    assign bus.halted      = r_halted;
    assign bus.fetch_count = r_count;

`ifdef FETCH_TRACE_EN
    localparam logic [IW:0] FULL = (IW + 1)'(TRACE_DEPTH);

    logic [AWIDTH-1:0] r_buf [TRACE_DEPTH];
    logic [IW-1:0]     r_wp;
    logic [IW:0]       r_fill;
    logic [AWIDTH-1:0] r_tpc;
    logic [IW-1:0]     w_rd;

    // newest entry sits just behind the write pointer
    assign w_rd = r_wp - IW'(1) - bus.trace_idx;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++)
                r_buf[i] <= '0;
            r_wp   <= '0;
            r_fill <= '0;
            r_tpc  <= '0;
        end else begin
            r_tpc <= ({1'b0, bus.trace_idx} < r_fill) ? r_buf[w_rd] : '0;
            if (w_take) begin
                r_buf[r_wp] <= w_pc;
                r_wp        <= r_wp + 1'b1;
                if (r_fill != FULL)
                    r_fill <= r_fill + 1'b1;
            end
        end

    assign bus.trace_pc   = r_tpc;
    assign bus.trace_fill = r_fill;
`else
    assign bus.trace_pc   = '0;
    assign bus.trace_fill = '0;
`endif
endmodule
